// File: rtl/uart_tx.sv
// UART transmitter: one start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Frame format and divisor are captured at accept so that mid-frame changes only affect later frames.
module uart_tx #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 104
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    input  logic                 tx_valid,
    input  logic [7:0]           tx_data,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 frame_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DEFAULT_DIV);

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t               state_r, state_next_s;
    logic [DIV_WIDTH-1:0] div_r, div_eff_s, div_snap_r;
    logic [DIV_WIDTH-1:0] cnt_r, cnt_next_s;
    logic [2:0]           bit_idx_r, bit_idx_next_s;
    logic                 stop_idx_r, stop_idx_next_s;
    logic [7:0]           data_r;
    logic                 par_en_r, par_odd_r, stop2_r;
    logic                 txd_r, txd_s;
    logic                 bit_end_s, last_stop_s, ready_s, accept_s;

    // Handshake and end-of-frame decode; ready also opens in the last stop clock for back-to-back frames.
    always_comb begin
        div_eff_s   = (div_r == DIV_ZERO) ? DIV_ONE : div_r;
        bit_end_s   = (cnt_r == DIV_ZERO);
        last_stop_s = (state_r == STOP) && bit_end_s && (stop_idx_r == stop2_r);
        ready_s     = !reset && ((state_r == IDLE) || last_stop_s);
        accept_s    = tx_valid && ready_s;
    end

    // Next-state, bit-timing counter and line level decode.
    always_comb begin
        state_next_s    = state_r;
        cnt_next_s      = cnt_r;
        bit_idx_next_s  = bit_idx_r;
        stop_idx_next_s = stop_idx_r;
        txd_s           = 1'b1;
        case (state_r)
            IDLE: begin
                txd_s = 1'b1;
                if (accept_s) begin
                    state_next_s = START;
                    cnt_next_s   = div_eff_s - DIV_ONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                txd_s = 1'b0;
                if (bit_end_s) begin
                    state_next_s   = DATA;
                    cnt_next_s     = div_snap_r - DIV_ONE;
                    bit_idx_next_s = 3'd0;
                end else begin
                    cnt_next_s = cnt_r - DIV_ONE;
                end
            end
            DATA: begin
                txd_s = data_r[bit_idx_r];
                if (bit_end_s) begin
                    cnt_next_s = div_snap_r - DIV_ONE;
                    if (bit_idx_r == 3'd7) begin
                        stop_idx_next_s = 1'b0;
                        if (par_en_r) begin
                            state_next_s = PARITY;
                        end else begin
                            state_next_s = STOP;
                        end
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r - DIV_ONE;
                end
            end
            PARITY: begin
                txd_s = parity_bit(data_r, par_odd_r);
                if (bit_end_s) begin
                    state_next_s    = STOP;
                    stop_idx_next_s = 1'b0;
                    cnt_next_s      = div_snap_r - DIV_ONE;
                end else begin
                    cnt_next_s = cnt_r - DIV_ONE;
                end
            end
            STOP: begin
                txd_s = 1'b1;
                if (last_stop_s) begin
                    if (accept_s) begin
                        state_next_s = START;
                        cnt_next_s   = div_eff_s - DIV_ONE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else if (bit_end_s) begin
                    stop_idx_next_s = 1'b1;
                    cnt_next_s      = div_snap_r - DIV_ONE;
                end else begin
                    cnt_next_s = cnt_r - DIV_ONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = DIV_ZERO;
                txd_s        = 1'b1;
            end
        endcase
    end

    // State, counters, frame snapshots and the registered line driver.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= DIV_ZERO;
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 1'b0;
            data_r     <= 8'h00;
            div_snap_r <= DIV_ONE;
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
            stop2_r    <= 1'b0;
            txd_r      <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            bit_idx_r  <= bit_idx_next_s;
            stop_idx_r <= stop_idx_next_s;
            txd_r      <= txd_s;
            if (accept_s) begin
                data_r     <= tx_data;
                div_snap_r <= div_eff_s;
                par_en_r   <= parity_en;
                par_odd_r  <= parity_odd;
                stop2_r    <= stop2;
            end
        end
    end

    // Divisor register; a new value is only picked up by the next accepted frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= DIV_RST;
        end else if (div_load) begin
            div_r <= div_value;
        end
    end

    assign tx_ready   = ready_s;
    assign txd        = txd_r;
    assign busy       = (state_r != IDLE);
    assign frame_done = last_stop_s && !reset;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (DEFAULT_DIV=4): a frame table plus hand sequences for
// back-to-back transfer and reset in the middle of a frame.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        reset, div_load, parity_en, parity_odd, stop2, tx_valid;
    logic [15:0] div_value;
    logic [7:0]  tx_data;
    logic        tx_ready, txd, busy, frame_done;

    int errors = 0;
    int checks = 0;

    logic txd_log   [0:127];
    logic busy_log  [0:127];
    logic ready_log [0:127];
    logic done_log  [0:127];

    logic [19:0] b2b_bits = 20'b11111111101000000000;

    typedef struct {
        logic [7:0]  data;
        logic        pe, po, s2, ld;
        logic [15:0] ldv;
        int          raise_at, drop_at;
        logic [7:0]  raise_data;
        int          load_at;
        logic [15:0] load_val;
        logic [11:0] bits;
        int          nbits, div, len;
    } vec_t;

    vec_t vecs [0:7];

    always #5 clk = ~clk;

    uart_tx #(.DIV_WIDTH(16), .DEFAULT_DIV(4)) dut (
        .clk(clk), .reset(reset), .div_load(div_load), .div_value(div_value),
        .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .txd(txd), .busy(busy), .frame_done(frame_done)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input logic pe, input logic po, input logic s2,
                               input logic ld, input logic [15:0] ldv, input logic keep);
        @(negedge clk);
        check("ready_before_accept", int'(tx_ready), 1);
        tx_data    = d;
        parity_en  = pe;
        parity_odd = po;
        stop2      = s2;
        div_load   = ld;
        div_value  = ldv;
        tx_valid   = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = keep;
        div_load = 1'b0;
        tx_data  = 8'h00;
    endtask

    task automatic watch(input int nclk, input int raise_at, input int drop_at, input logic [7:0] raise_data,
                         input int load_at, input logic [15:0] load_val);
        for (int k = 1; k <= nclk; k++) begin
            @(negedge clk);
            txd_log[k]   = txd;
            busy_log[k]  = busy;
            ready_log[k] = tx_ready;
            done_log[k]  = frame_done;
            if (k == raise_at) begin
                tx_valid = 1'b1;
                tx_data  = raise_data;
            end
            if (k == drop_at) tx_valid = 1'b0;
            if (k == load_at) begin
                div_load  = 1'b1;
                div_value = load_val;
            end else if (k == load_at + 1) begin
                div_load = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input string name, input logic [11:0] bits, input int nbits, input int div, input int len);
        int   done_cnt;
        int   busy_cnt;
        int   txd_err;
        logic exp_txd;
        done_cnt = 0;
        busy_cnt = 0;
        txd_err  = 0;
        for (int k = 1; k <= len + 4; k++) begin
            done_cnt += int'(done_log[k]);
            busy_cnt += int'(busy_log[k]);
            if (k == 1 || k > nbits * div + 1) exp_txd = 1'b1;
            else exp_txd = bits[(k - 2) / div];
            if (txd_log[k] !== exp_txd) txd_err++;
        end
        check({name, "_txd_errs"}, txd_err, 0);
        check({name, "_done_at_end"}, int'(done_log[len]), 1);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_busy_clocks"}, busy_cnt, len);
        check({name, "_busy_last"}, int'(busy_log[len]), 1);
    endtask

    initial begin
        reset = 1'b1; div_load = 1'b0; div_value = 16'd0; parity_en = 1'b0;
        parity_odd = 1'b0; stop2 = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;

        //         data   pe    po    s2    ld    ldv    raise drop rdata  load lval   bits     nb div len
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 0,  0,  8'h00, 0,  16'd0, 12'h34A, 10, 4, 40};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 0,  0,  8'h00, 0,  16'd0, 12'h60E, 11, 4, 44};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 0,  0,  8'h00, 0,  16'd0, 12'h40E, 11, 4, 44};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 0,  0,  8'h00, 0,  16'd0, 12'hE0E, 12, 4, 48};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 10, 30, 8'h3C, 0,  16'd0, 12'h678, 11, 4, 44};
        vecs[5] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 0,  0,  8'h00, 15, 16'd2, 12'h2AA, 10, 4, 40};
        vecs[6] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 0,  0,  8'h00, 0,  16'd0, 12'h34A, 10, 2, 20};
        vecs[7] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4, 0,  0,  8'h00, 0,  16'd0, 12'h34A, 10, 1, 10};

        repeat (2) @(negedge clk);
        check("reset_ready", int'(tx_ready), 0);
        check("reset_txd", int'(txd), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(frame_done), 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", int'(tx_ready), 1);

        for (int i = 0; i < 8; i++) begin
            start_frame(vecs[i].data, vecs[i].pe, vecs[i].po, vecs[i].s2, vecs[i].ld, vecs[i].ldv, 1'b0);
            watch(vecs[i].len + 4, vecs[i].raise_at, vecs[i].drop_at, vecs[i].raise_data,
                  vecs[i].load_at, vecs[i].load_val);
            check_frame($sformatf("vec%0d", i), vecs[i].bits, vecs[i].nbits, vecs[i].div, vecs[i].len);
        end

        // Back-to-back 0x00 then 0xFF with tx_valid held high across the boundary.
        begin
            int ready_cnt, done_cnt, busy_cnt, txd_err;
            logic exp_txd;
            ready_cnt = 0; done_cnt = 0; busy_cnt = 0; txd_err = 0;
            start_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
            watch(84, 1, 41, 8'hFF, 0, 16'd0);
            for (int k = 1; k <= 84; k++) begin
                if (k <= 80) ready_cnt += int'(ready_log[k]);
                done_cnt += int'(done_log[k]);
                busy_cnt += int'(busy_log[k]);
                if (k == 1 || k > 81) exp_txd = 1'b1;
                else exp_txd = b2b_bits[(k - 2) / 4];
                if (txd_log[k] !== exp_txd) txd_err++;
            end
            check("b2b_ready_count", ready_cnt, 2);
            check("b2b_ready_40", int'(ready_log[40]), 1);
            check("b2b_ready_80", int'(ready_log[80]), 1);
            check("b2b_done_count", done_cnt, 2);
            check("b2b_done_40", int'(done_log[40]), 1);
            check("b2b_done_80", int'(done_log[80]), 1);
            check("b2b_busy_clocks", busy_cnt, 80);
            check("b2b_txd_errs", txd_err, 0);
        end

        // Reset during data bit 3 of a frame whose accept also loaded divisor 2.
        begin
            int done_cnt;
            done_cnt = 0;
            start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0);
            for (int k = 1; k <= 18; k++) begin
                @(negedge clk);
                done_cnt += int'(frame_done);
            end
            reset = 1'b1;
            #1;
            check("midreset_ready_low", int'(tx_ready), 0);
            check("midreset_done_low", int'(frame_done), 0);
            @(negedge clk);
            check("midreset_txd", int'(txd), 1);
            check("midreset_busy", int'(busy), 0);
            done_cnt += int'(frame_done);
            reset = 1'b0;
            @(negedge clk);
            check("midreset_ready_after", int'(tx_ready), 1);
            done_cnt += int'(frame_done);
            check("midreset_no_done", done_cnt, 0);
        end

        start_frame(vecs[0].data, vecs[0].pe, vecs[0].po, vecs[0].s2, 1'b0, 16'd0, 1'b0);
        watch(vecs[0].len + 4, 0, 0, 8'h00, 0, 16'd0);
        check_frame("after_reset", vecs[0].bits, vecs[0].nbits, vecs[0].div, vecs[0].len);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
